wb_unit: RTL and testbench

//  Writeback stage between execute/LSU and the register-stack write port (rd, rd_value, wen).

---
 rtl/wb_unit.sv | 172 +++++++++++++++++
 tb/tb_wb_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - writeback stage: load alignment/extension, single register write, commit pulse
//
// Ports:
//   clk, rst                          clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready               instruction handshake from execute; ready only in IDLE
//   in_rd, in_wen, in_alu_res         destination index, write intent, non-load write data
//   in_is_load, in_funct3, in_addr_lo load flag, load type, load address bits [1:0]
//   mem_rvalid / mem_rready           memory read response handshake; ready only while waiting
//   mem_rdata                         word-aligned memory read data
//   rd, rd_value, wen                 register write port; wen is a one-cycle pulse
//   commit                            one-cycle retire pulse, with or without a write
//   err_misalign, err_timeout         sticky error flags, cleared only by rst

module wb_unit #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    input  logic [31:0] in_alu_res,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        mem_rready,
    output logic [4:0]  rd,
    output logic [31:0] rd_value,
    output logic        wen,
    output logic        commit,
    output logic        err_misalign,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_COMMIT   = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [4:0]  cap_rd;
    logic        cap_wen;
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_addr_lo;
    logic        suppress;

    logic        accept;
    logic        misalign;
    logic        mem_hit;
    logic        timed_out;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign accept    = (state == S_IDLE) && in_valid;
    assign mem_hit   = (state == S_WAIT_MEM) && mem_rvalid;
    // Data arriving on the last allowed cycle takes priority over the abort.
    assign timed_out = (state == S_WAIT_MEM) && !mem_rvalid && (cnt == CNT_LAST);

    // Unlisted funct3 codes are treated as word loads, so they need full alignment.
    always_comb begin
        misalign = 1'b0;
        case (in_funct3)
            3'b000, 3'b100: misalign = 1'b0;
            3'b001, 3'b101: misalign = in_addr_lo[0];
            default:        misalign = (in_addr_lo != 2'b00);
        endcase
    end

    assign byte_sel = mem_rdata[{cap_addr_lo, 3'b000} +: 8];
    assign half_sel = mem_rdata[{cap_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = mem_rdata;
        case (cap_funct3)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt = (in_is_load && !misalign) ? S_WAIT_MEM : S_COMMIT;
                end
            end
            S_WAIT_MEM: begin
                if (mem_hit || timed_out) begin
                    state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready   = (state == S_IDLE);
        mem_rready = (state == S_WAIT_MEM);
        commit     = (state == S_COMMIT);
        wen        = (state == S_COMMIT) && cap_wen && (cap_rd != 5'd0) && !suppress;
    end

    // Capture, wait counter, write port registers and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 16'd0;
            cap_rd       <= 5'd0;
            cap_wen      <= 1'b0;
            cap_funct3   <= 3'd0;
            cap_addr_lo  <= 2'd0;
            suppress     <= 1'b0;
            rd           <= 5'd0;
            rd_value     <= 32'd0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (accept) begin
                cnt         <= 16'd0;
                cap_rd      <= in_rd;
                cap_wen     <= in_wen;
                cap_funct3  <= in_funct3;
                cap_addr_lo <= in_addr_lo;
                suppress    <= in_is_load && misalign;
                if (in_is_load && misalign) begin
                    err_misalign <= 1'b1;
                end
                // Non-loads go straight to COMMIT, so the write port can load now.
                if (!in_is_load) begin
                    rd       <= in_rd;
                    rd_value <= in_alu_res;
                end
            end
            if (state == S_WAIT_MEM) begin
                cnt <= cnt + 16'd1;
            end
            if (mem_hit) begin
                rd       <= cap_rd;
                rd_value <= load_ext;
            end
            if (timed_out) begin
                suppress    <= 1'b1;
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - self-checking bench for wb_unit: directed cases plus randomized instruction stream

module tb_wb_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [31:0] in_alu_res;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rready;
    logic [4:0]  rd;
    logic [31:0] rd_value;
    logic        wen;
    logic        commit;
    logic        err_misalign;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    // Reference sticky error state
    logic m_mis = 1'b0;
    logic m_to  = 1'b0;

    wb_unit #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_wen      (in_wen),
        .in_alu_res  (in_alu_res),
        .in_is_load  (in_is_load),
        .in_funct3   (in_funct3),
        .in_addr_lo  (in_addr_lo),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_rready  (mem_rready),
        .rd          (rd),
        .rd_value    (rd_value),
        .wen         (wen),
        .commit      (commit),
        .err_misalign(err_misalign),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_misalign(input int f3, input int a);
        if (f3 == 0 || f3 == 4) return 1'b0;
        if (f3 == 1 || f3 == 5) return (a % 2) != 0;
        return a != 0;
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input int a, input logic [31:0] w);
        longint unsigned word = longint'(w);
        longint unsigned b = (word >> (8 * a)) % 256;
        longint unsigned h = (word >> (16 * (a / 2))) % 65536;
        longint unsigned r;
        case (f3)
            0:       r = (b >= 128) ? (b + 64'hFFFF_FF00) : b;
            4:       r = b;
            1:       r = (h >= 32768) ? (h + 64'hFFFF_0000) : h;
            5:       r = h;
            default: r = word;
        endcase
        return r[31:0];
    endfunction

    function automatic logic [31:0] neg_to_word(input int v);
        return 32'(v);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction. wait_cycles < 0 means the memory never answers.
    task automatic do_instr(input string tag, input bit is_load, input logic [4:0] r, input bit we,
                            input logic [31:0] alu, input int f3, input int a,
                            input int wait_cycles, input logic [31:0] data);
        bit mis;
        bit exp_wen;
        logic [31:0] exp_val;
        mis = is_load && ref_misalign(f3, a);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        in_rd      = r;
        in_wen     = we;
        in_alu_res = alu;
        in_is_load = is_load;
        in_funct3  = 3'(f3);
        in_addr_lo = 2'(a);
        step();
        in_valid   = 1'b0;
        in_alu_res = $urandom;
        in_rd      = 5'($urandom);
        exp_wen    = we && (r != 5'd0);
        exp_val    = alu;
        if (mis) begin
            m_mis   = 1'b1;
            exp_wen = 1'b0;
        end else if (is_load) begin
            check({tag, " mem_rready"}, 32'(mem_rready), 32'd1);
            check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
            if (wait_cycles < 0) begin
                for (int i = 0; i < 7; i++) begin
                    mem_rdata = $urandom;
                    step();
                    check({tag, " no early commit"}, 32'(commit), 32'd0);
                end
                step();
                m_to    = 1'b1;
                exp_wen = 1'b0;
            end else begin
                for (int i = 0; i < wait_cycles; i++) begin
                    check({tag, " waiting commit"}, 32'(commit), 32'd0);
                    step();
                end
                mem_rvalid = 1'b1;
                mem_rdata  = data;
                step();
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                exp_val    = ref_load(f3, a, data);
            end
        end
        check({tag, " commit"}, 32'(commit), 32'd1);
        check({tag, " wen"}, 32'(wen), 32'(exp_wen));
        if (exp_wen) begin
            check({tag, " rd"}, 32'(rd), 32'(r));
            check({tag, " rd_value"}, rd_value, exp_val);
        end
        check({tag, " err_misalign"}, 32'(err_misalign), 32'(m_mis));
        check({tag, " err_timeout"}, 32'(err_timeout), 32'(m_to));
        check({tag, " in_ready commit"}, 32'(in_ready), 32'd0);
        // A stray response outside WAIT_MEM must be ignored.
        mem_rvalid = 1'($urandom);
        step();
        mem_rvalid = 1'b0;
        check({tag, " commit pulse ends"}, 32'(commit), 32'd0);
        check({tag, " wen pulse ends"}, 32'(wen), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_rd      = 5'd0;
        in_wen     = 1'b0;
        in_alu_res = 32'd0;
        in_is_load = 1'b0;
        in_funct3  = 3'd0;
        in_addr_lo = 2'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        #2;
        check("reset rd", 32'(rd), 32'd0);
        check("reset rd_value", rd_value, 32'd0);
        check("reset wen", 32'(wen), 32'd0);
        check("reset commit", 32'(commit), 32'd0);
        check("reset err_misalign", 32'(err_misalign), 32'd0);
        check("reset err_timeout", 32'(err_timeout), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset mem_rready", 32'(mem_rready), 32'd0);
        #20;
        rst = 1'b0;
        step();

        do_instr("add", 1'b0, 5'd5, 1'b1, 32'h1234, 0, 0, 0, 32'd0);
        do_instr("lb", 1'b1, 5'd7, 1'b1, 32'd0, 0, 3, 4, 32'h80FF_0000);
        check("lb value", rd_value, 32'hFFFF_FF80);
        do_instr("lbu", 1'b1, 5'd7, 1'b1, 32'd0, 4, 3, 4, 32'h80FF_0000);
        check("lbu value", rd_value, 32'h0000_0080);
        do_instr("lh misalign", 1'b1, 5'd9, 1'b1, 32'd0, 1, 1, 0, 32'd0);
        do_instr("add after misalign", 1'b0, 5'd3, 1'b1, 32'hCAFE_F00D, 0, 0, 0, 32'd0);
        do_instr("rd zero", 1'b0, 5'd0, 1'b1, 32'hDEAD_BEEF, 0, 0, 0, 32'd0);
        do_instr("lw last cycle data", 1'b1, 5'd11, 1'b1, 32'd0, 2, 0, 7, 32'h1357_9BDF);
        do_instr("lh upper", 1'b1, 5'd12, 1'b1, 32'd0, 1, 2, 1, 32'h8001_7FFF);
        check("lh upper value", rd_value, neg_to_word(-32767));
        do_instr("load timeout", 1'b1, 5'd13, 1'b1, 32'd0, 2, 0, -1, 32'd0);

        for (int n = 0; n < 40; n++) begin
            int f3;
            int sel;
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: f3 = 0;
                1: f3 = 1;
                2: f3 = 2;
                3: f3 = 4;
                4: f3 = 5;
                5: f3 = 3;
                default: f3 = int'($urandom_range(0, 7));
            endcase
            do_instr("random", 1'($urandom), 5'($urandom), 1'($urandom_range(0, 3) != 0),
                     $urandom, f3, int'($urandom_range(0, 3)),
                     ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 7)), $urandom);
        end

        // Reset while waiting on memory: the load is dropped and a late response ignored.
        check("pre-reset in_ready", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        in_rd      = 5'd20;
        in_wen     = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = 3'd2;
        in_addr_lo = 2'd0;
        step();
        in_valid = 1'b0;
        check("rst-case mem_rready", 32'(mem_rready), 32'd1);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async rst commit", 32'(commit), 32'd0);
        check("async rst err_timeout", 32'(err_timeout), 32'd0);
        check("async rst err_misalign", 32'(err_misalign), 32'd0);
        m_mis = 1'b0;
        m_to  = 1'b0;
        step();
        #3;
        rst = 1'b0;
        check("in_ready after reset", 32'(in_ready), 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("post-reset commit", 32'(commit), 32'd0);
            check("post-reset wen", 32'(wen), 32'd0);
            check("post-reset rd_value", rd_value, 32'd0);
            step();
        end
        do_instr("add after reset", 1'b0, 5'd31, 1'b1, 32'h0BAD_F00D, 0, 0, 0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
